// File: rtl/code_decoder.sv
// Decodes a 7-bit code word (Gray or one-hot-offset, chosen by USE_GREY) into a 3-bit value.
// Single-stage valid/ready output register with a saturating illegal-word counter.
module code_decoder #(
    parameter int USE_GREY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [6:0] in_code,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_data,
    output logic       out_err,
    input  logic       err_clr,
    output logic [7:0] err_count
);

    // Result packing for both decoders: {err, data[2:0]}.
    function automatic logic [3:0] gray_decode(input logic [6:0] c);
        return {(c[6:3] != 4'd0), c[2], c[2] ^ c[1], c[2] ^ c[1] ^ c[0]};
    endfunction

    function automatic logic [3:0] onehot_decode(input logic [6:0] c);
        logic [2:0] cnt;
        logic [2:0] pos;
        cnt = 3'd0;
        pos = 3'd0;
        for (int k = 0; k < 7; k++) begin
            if (c[k]) begin
                cnt = cnt + 3'd1;
                pos = 3'(k + 1);
            end else begin
                cnt = cnt;
            end
        end
        if (cnt == 3'd0) begin
            return 4'b0000;
        end else if (cnt == 3'd1) begin
            return {1'b0, pos};
        end else begin
            return 4'b1000;
        end
    endfunction

    logic [3:0] w_dec;
    logic       w_accept;
    logic       r_out_valid;
    logic [2:0] r_out_data;
    logic       r_out_err;
    logic [7:0] r_err_count;

    // Only the selected decoder is elaborated.
    generate
        if (USE_GREY != 0) begin : g_gray
            assign w_dec = gray_decode(in_code);
        end else begin : g_onehot
            assign w_dec = onehot_decode(in_code);
        end
    endgenerate

    // Handshake: ready whenever the output register is empty or being drained.
    always_comb begin
        in_ready = !r_out_valid || out_ready;
        w_accept = in_valid && in_ready;
    end

    // Output register: load on accept, clear on drain, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 3'd0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_dec[2:0];
            r_out_err   <= w_dec[3];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Illegal-word counter: counts at accept time, clear wins, saturates at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= 8'd0;
        end else if (err_clr) begin
            r_err_count <= 8'd0;
        end else if (w_accept && w_dec[3] && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end else begin
            r_err_count <= r_err_count;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_code_decoder.sv
// Scoreboard bench driving one Gray-mode and one one-hot-mode decoder with shared stimulus.
module tb_code_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [6:0] in_code;
    logic       out_ready;
    logic       err_clr;

    logic       g_in_ready, g_out_valid, g_out_err;
    logic [2:0] g_out_data;
    logic [7:0] g_err_count;
    logic       o_in_ready, o_out_valid, o_out_err;
    logic [2:0] o_out_data;
    logic [7:0] o_err_count;

    int n_cmp;
    int n_bad;

    logic [3:0] q_g[$];
    logic [3:0] q_o[$];
    logic       m_valid;
    int         m_cnt_g;
    int         m_cnt_o;

    code_decoder #(.USE_GREY(1)) u_gray (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
        .in_ready(g_in_ready), .out_valid(g_out_valid), .out_ready(out_ready),
        .out_data(g_out_data), .out_err(g_out_err), .err_clr(err_clr),
        .err_count(g_err_count)
    );

    code_decoder #(.USE_GREY(0)) u_onehot (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
        .in_ready(o_in_ready), .out_valid(o_out_valid), .out_ready(out_ready),
        .out_data(o_out_data), .out_err(o_out_err), .err_clr(err_clr),
        .err_count(o_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference decoders, {err, data}.
    function automatic logic [3:0] ref_gray(input logic [6:0] c);
        logic [2:0] g;
        g = c[2:0];
        return {(c > 7'd7), g ^ (g >> 1) ^ (g >> 2)};
    endfunction

    function automatic logic [3:0] ref_onehot(input logic [6:0] c);
        if (c == 7'd0) return 4'd0;
        if ($countones(c) == 1) return {1'b0, 3'($clog2(c) + 1)};
        return 4'b1000;
    endfunction

    // Pop one expectation per output transfer and compare.
    task automatic sb_pop(input string tag, inout logic [3:0] q[$], input logic [2:0] d, input logic e);
        logic [3:0] x;
        if (q.size() == 0) begin
            check_eq({tag, "_queue_underflow"}, 32'd1, 32'd0);
        end else begin
            x = q.pop_front();
            check_eq({tag, "_data"}, {29'd0, d}, {29'd0, x[2:0]});
            check_eq({tag, "_err"}, {31'd0, e}, {31'd0, x[3]});
        end
    endtask

    // One clock cycle of stimulus, entered and left just after a falling edge.
    task automatic step(input logic v, input logic [6:0] c, input logic rdy, input logic clr);
        logic acc;
        in_valid  = v;
        in_code   = c;
        out_ready = rdy;
        err_clr   = clr;
        #1;
        check_eq("g_in_ready", {31'd0, g_in_ready}, {31'd0, (!m_valid || rdy)});
        check_eq("o_in_ready", {31'd0, o_in_ready}, {31'd0, (!m_valid || rdy)});
        check_eq("g_out_valid", {31'd0, g_out_valid}, {31'd0, m_valid});
        check_eq("o_out_valid", {31'd0, o_out_valid}, {31'd0, m_valid});
        if (g_out_valid && rdy) sb_pop("g", q_g, g_out_data, g_out_err);
        if (o_out_valid && rdy) sb_pop("o", q_o, o_out_data, o_out_err);
        acc = v && (!m_valid || rdy);
        if (acc) begin
            q_g.push_back(ref_gray(c));
            q_o.push_back(ref_onehot(c));
        end
        if (clr) begin
            m_cnt_g = 0;
            m_cnt_o = 0;
        end else if (acc) begin
            if (ref_gray(c)  [3] && m_cnt_g < 255) m_cnt_g++;
            if (ref_onehot(c)[3] && m_cnt_o < 255) m_cnt_o++;
        end
        if (acc) m_valid = 1'b1;
        else if (rdy) m_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("g_err_count", {24'd0, g_err_count}, m_cnt_g);
        check_eq("o_err_count", {24'd0, o_err_count}, m_cnt_o);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_cnt_g = 0;
        m_cnt_o = 0;
        q_g.delete();
        q_o.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_g_valid"}, {31'd0, g_out_valid}, 32'd0);
        check_eq({tag, "_o_valid"}, {31'd0, o_out_valid}, 32'd0);
        check_eq({tag, "_g_data"}, {29'd0, g_out_data}, 32'd0);
        check_eq({tag, "_g_err"}, {31'd0, g_out_err}, 32'd0);
        check_eq({tag, "_o_err"}, {31'd0, o_out_err}, 32'd0);
        check_eq({tag, "_g_cnt"}, {24'd0, g_err_count}, 32'd0);
        check_eq({tag, "_o_cnt"}, {24'd0, o_err_count}, 32'd0);
        check_eq({tag, "_g_ready"}, {31'd0, g_in_ready}, 32'd1);
    endtask

    initial begin
        logic [2:0] held_g;
        logic [2:0] held_o;
        logic [6:0] oh_codes[8];
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_code = 7'h7F;
        out_ready = 1'b0;
        err_clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Gray stream 0..7 at full throughput.
        for (int i = 0; i < 8; i++) step(1'b1, 7'(i), 1'b1, 1'b0);
        step(1'b0, 7'h00, 1'b1, 1'b0);

        // One-hot legal words.
        oh_codes = '{7'h00, 7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40};
        for (int i = 0; i < 8; i++) step(1'b1, oh_codes[i], 1'b1, 1'b0);

        // Illegal words in each mode.
        step(1'b1, 7'h03, 1'b1, 1'b0);
        step(1'b1, 7'h0B, 1'b1, 1'b0);
        step(1'b0, 7'h7F, 1'b1, 1'b0);

        // Back-pressure: hold result for 3 cycles, then drain and accept together.
        step(1'b1, 7'h05, 1'b0, 1'b0);
        held_g = g_out_data;
        held_o = o_out_data;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 7'h12, 1'b0, 1'b0);
            check_eq("stall_g_data", {29'd0, g_out_data}, {29'd0, ref_gray(7'h05) [2:0]});
            check_eq("stall_o_data", {29'd0, o_out_data}, {29'd0, ref_onehot(7'h05)[2:0]});
            check_eq("stall_g_hold", {29'd0, g_out_data}, {29'd0, held_g});
            check_eq("stall_o_hold", {29'd0, o_out_data}, {29'd0, held_o});
        end
        step(1'b1, 7'h12, 1'b1, 1'b0);
        step(1'b0, 7'h00, 1'b1, 1'b0);

        // Random traffic, including invalid cycles carrying garbage.
        for (int i = 0; i < 60; i++)
            step(1'(($urandom_range(0, 3) != 0)), 7'($urandom_range(0, 127)),
                 1'(($urandom_range(0, 2) != 0)), 1'b0);
        step(1'b0, 7'h7F, 1'b1, 1'b1);

        // Saturation then clear together with one more illegal word.
        for (int i = 0; i < 300; i++) step(1'b1, 7'h7F, 1'b1, 1'b0);
        check_eq("sat_g", {24'd0, g_err_count}, 32'd255);
        check_eq("sat_o", {24'd0, o_err_count}, 32'd255);
        step(1'b1, 7'h7F, 1'b1, 1'b1);
        check_eq("clr_g", {24'd0, g_err_count}, 32'd0);
        step(1'b0, 7'h7F, 1'b1, 1'b0);

        // Asynchronous reset while holding an illegal result.
        step(1'b1, 7'h7F, 1'b0, 1'b0);
        check_eq("pre_rst_g_err", {31'd0, g_out_err}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_state("in_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 7'h06, 1'b1, 1'b0);
        step(1'b0, 7'h00, 1'b1, 1'b0);

        check_eq("g_queue_left", q_g.size(), 32'd0);
        check_eq("o_queue_left", q_o.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
